// File: rtl/reg_rename_free_list.sv
// Circular free list of physical registers for the rename stage. It grants one
// register per accepted rename, drives the map-table update and takes back committed frees.
module reg_rename_free_list #(
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int NUM_PHYS_REGS       = 128,
    parameter int NUM_ARCH_REGS       = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic [4:0]                     alloc_arch_rd,
    output logic [REG_FILE_ADDR_WIDTH-1:0] alloc_phys_rd,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] map_old_phys_rd,
    output logic [REG_FILE_ADDR_WIDTH-1:0] alloc_old_phys_rd,
    output logic                           update_map,
    output logic [4:0]                     update_map_addr,
    output logic [REG_FILE_ADDR_WIDTH-1:0] new_map_value,
    output logic                           ready_in,
    input  logic                           free_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] free_phys,
    output logic [6:0]                     free_count,
    output logic                           init_done,
    output logic                           err_overflow
);

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [6:0]       COUNT_FULL = 7'(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                         state_q, state_d;
    logic [PTR_W-1:0]               init_cnt_q;
    logic [PTR_W-1:0]               rd_ptr_q;
    logic [PTR_W-1:0]               wr_ptr_q;
    logic [6:0]                     free_count_q;
    logic                           err_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] entries [DEPTH];

    logic                           in_run;
    logic                           rd_zero;
    logic                           consume;
    logic                           free_accept;
    logic                           free_drop;
    logic                           wr_en;
    logic [REG_FILE_ADDR_WIDTH-1:0] wr_data;

    // DEPTH is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_cnt_q == PTR_LAST) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        in_run      = (state_q == S_RUN);
        rd_zero     = (alloc_arch_rd == 5'd0);
        alloc_ready = in_run && (rd_zero || (free_count_q != 7'd0));
        consume     = alloc_valid && alloc_ready && !rd_zero;
        // free_phys==0 is the hardwired zero register and is never returned.
        free_accept = in_run && free_valid && (free_phys != '0) && (free_count_q != COUNT_FULL);
        free_drop   = free_valid && (!in_run || ((free_phys != '0) && (free_count_q == COUNT_FULL)));

        wr_en   = !in_run || free_accept;
        wr_data = in_run ? free_phys
                         : REG_FILE_ADDR_WIDTH'(NUM_ARCH_REGS) + REG_FILE_ADDR_WIDTH'(init_cnt_q);

        alloc_phys_rd     = rd_zero ? '0 : entries[rd_ptr_q];
        alloc_old_phys_rd = map_old_phys_rd;
        update_map        = consume;
        update_map_addr   = alloc_arch_rd;
        new_map_value     = alloc_phys_rd;
        ready_in          = 1'b0;
        free_count        = free_count_q;
        init_done         = in_run;
        err_overflow      = err_q;
    end

    always_ff @(posedge clock) begin
        if (wr_en) entries[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            init_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            free_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (free_drop) err_q <= 1'b1;
            if (!in_run) begin
                init_cnt_q   <= ptr_inc(init_cnt_q);
                wr_ptr_q     <= ptr_inc(wr_ptr_q);
                free_count_q <= free_count_q + 7'd1;
            end else begin
                if (consume)     rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (free_accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
                case ({free_accept, consume})
                    2'b10:   free_count_q <= free_count_q + 7'd1;
                    2'b01:   free_count_q <= free_count_q - 7'd1;
                    default: free_count_q <= free_count_q;
                endcase
            end
        end
    end

endmodule

// File: doc/reg_rename_free_list.md
Name: reg_rename_free_list

Overview:
- Scheduler for physical register allocation at rename.
- Holds the circular free list of physical registers and hands one out per accepted rename request.
- Drives the register map table update port for that request and reports the previous mapping of rd to the reorder stage.
- Takes back physical registers released at commit.
- Sits between the rename stage, the register map table and the commit logic.

Parameters:
- REG_FILE_ADDR_WIDTH, 7, width of a physical register index.
- NUM_PHYS_REGS, 128, total physical registers.
- NUM_ARCH_REGS, 32, architectural registers. Physical 0..NUM_ARCH_REGS-1 are mapped at reset and never start on the free list.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- alloc_valid  in  1  rename stage requests a rename.
- alloc_ready  out  1  free list can accept the request this cycle.
- alloc_arch_rd  in  5  architectural destination of the request.
- alloc_phys_rd  out  REG_FILE_ADDR_WIDTH  physical register granted (head of free list).
- map_old_phys_rd  in  REG_FILE_ADDR_WIDTH  current mapping of alloc_arch_rd, read combinationally from the map table.
- alloc_old_phys_rd  out  REG_FILE_ADDR_WIDTH  previous mapping, passed to the reorder buffer for later freeing.
- update_map  out  1  map table write strobe.
- update_map_addr  out  5  map table write address.
- new_map_value  out  REG_FILE_ADDR_WIDTH  map table write data.
- ready_in  out  1  ready bit written with the new mapping.
- free_valid  in  1  commit returns a physical register.
- free_phys  in  REG_FILE_ADDR_WIDTH  register being returned.
- free_count  out  7  number of entries on the free list (0..96).
- init_done  out  1  high once initialisation is complete.
- err_overflow  out  1  sticky: a free was dropped.

Behaviour:
- Storage is DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS = 96 entries with no reset on the array.
- Read pointer, write pointer and free_count are all registered.
- Pointers wrap explicitly from DEPTH-1 to 0, since DEPTH is not a power of two.

State machine: INIT, RUN.
- Reset (asynchronous, any time, including mid-operation):
  - state=INIT, init counter=0, rd_ptr=0, wr_ptr=0, free_count=0, init_done=0, err_overflow=0.
  - All in-flight state is discarded.
- INIT:
  - Each cycle writes entry[k] = NUM_ARCH_REGS + k, with wr_ptr=k and free_count=k+1.
  - After k = DEPTH-1, goes to RUN with wr_ptr wrapped to 0 and free_count=96.
  - INIT takes exactly 96 cycles after reset deassertion.
  - alloc_ready=0 throughout INIT.
  - A free_valid during INIT is dropped and sets err_overflow.
- RUN: init_done=1. Transitions only back to INIT, via reset.

Allocation (RUN):
- alloc_phys_rd = entry[rd_ptr] (combinational).
- alloc_old_phys_rd = map_old_phys_rd (pass-through).
- alloc_arch_rd=0:
  - alloc_ready=1.
  - Handshake completes without consuming an entry.
  - update_map=0; alloc_phys_rd is forced to 0.
- alloc_arch_rd!=0:
  - alloc_ready = (free_count != 0).
  - On fire (valid && ready), combinationally in the same cycle: update_map=1, update_map_addr=alloc_arch_rd, new_map_value=alloc_phys_rd, ready_in=0.
  - The map table captures the update at the same edge at which rd_ptr advances.
  - Back-to-back renames of the same rd therefore see the new mapping the next cycle.
- update_map=0 whenever there is no fire.

Free (RUN):
- free_valid with free_phys < NUM_ARCH_REGS is ignored when free_phys=0.
- Otherwise: entry[wr_ptr] = free_phys and wr_ptr advances.
- If free_count=96, the free is dropped and err_overflow is set.

Simultaneous events:
- Allocate and free in the same cycle: free_count unchanged, both pointers advance.
- No bypass: with free_count=0, a same-cycle free does not satisfy the allocation (alloc_ready=0); the entry is usable next cycle.
- free_count arithmetic saturates at neither end; the guards above keep it within 0..96.

Test Plan:
- Reset, release, hold alloc_valid=0 for 100 cycles -> init_done rises exactly 96 cycles after release; free_count=96; alloc_ready=1.
- Rename rd=5, map_old_phys_rd=5 -> alloc_phys_rd=32, update_map=1, update_map_addr=5, new_map_value=32, ready_in=0, alloc_old_phys_rd=5. Next rename of rd=7 -> grants 33; free_count=94.
- 96 renames with rd=1..31 cycling -> grants 32..127 in order; then free_count=0 and alloc_ready=0 for rd!=0, while alloc_ready=1 for rd=0 and update_map=0.
- At free_count=0, assert free_valid=1 with free_phys=40 together with alloc_valid -> no grant that cycle. Next cycle: grant 40, free_count returns to 0.
- Simultaneous alloc and free at free_count=50 -> free_count stays 50. Freeing 96 more entries overfills -> err_overflow=1, stays set until reset.
- Assert reset asynchronously mid-stream, between clock edges -> alloc_ready, update_map, free_count and init_done drop to 0 immediately. After release, the next grant following INIT is 32.
